// File: rtl/dmem_arb_pkg.sv
// Shared defaults and the ownership encoding for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 10;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2
  } owner_e;

endpackage

// File: rtl/dmem_arb_age_ctr.sv
// Debug wait counter: counts cycles a debug request goes ungranted and
// raises force_dbg once it reaches MAX_WAIT so the requester cannot starve.
module dmem_arb_age_ctr #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic dbg_req,
  input  logic dbg_gnt,
  output logic force_dbg
);

  logic [3:0] wait_cnt;

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= 4'd0;
    end else if (!dbg_req || dbg_gnt) begin
      wait_cnt <= 4'd0;
    end else if (wait_cnt != 4'hF) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  // A request dropped at the threshold must not pull the RAM away from the CPU.
  assign force_dbg = dbg_req && (wait_cnt == 4'(MAX_WAIT));

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the CPU EM stage and a debug/loader
// port. Define DMEM_ARB_AGING_EN to add debug starvation protection.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_halted,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_rvalid,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
    $error("dmem_arbiter: MAX_WAIT must be within 1..15");
  end

  owner_e owner;
  logic   cpu_eff;
  logic   force_dbg;

  assign cpu_eff = cpu_req && !cpu_halted;

`ifdef DMEM_ARB_AGING_EN
  dmem_arb_age_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_age_ctr (
    .clk       (clk),
    .rst       (rst),
    .dbg_req   (dbg_req),
    .dbg_gnt   (dbg_gnt),
    .force_dbg (force_dbg)
  );
`else
  assign force_dbg = 1'b0;
`endif

  // Ownership is forced to NONE during reset so no access can start.
  always_comb begin
    owner = OWN_NONE;
    if (rst) begin
      owner = OWN_NONE;
    end else if (force_dbg) begin
      owner = OWN_DBG;
    end else if (cpu_eff) begin
      owner = OWN_CPU;
    end else if (dbg_req) begin
      owner = OWN_DBG;
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    cpu_stall = 1'b0;
    dbg_gnt   = 1'b0;
    unique case (owner)
      OWN_CPU: begin
        ram_we    = cpu_we;
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
      end
      OWN_DBG: begin
        ram_we    = dbg_we;
        ram_addr  = dbg_addr;
        ram_wdata = dbg_wdata;
        dbg_gnt   = 1'b1;
        cpu_stall = cpu_eff;
      end
      default: ;
    endcase
  end

  assign cpu_rdata = ram_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbg_rdata  <= '0;
      dbg_rvalid <= 1'b0;
    end else begin
      dbg_rvalid <= dbg_gnt && !dbg_we;
      if (dbg_gnt && !dbg_we) begin
        dbg_rdata <= ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random traffic
// compared against a cycle-level behavioural model of the arbitration rules.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int AW = 10;
  localparam int DW = 10;
  localparam int MW = 4;
`ifdef DMEM_ARB_AGING_EN
  localparam bit AGING = 1'b1;
`else
  localparam bit AGING = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_halted, cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          cpu_stall;
  logic          dbg_req, dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata, dbg_rdata;
  logic          dbg_gnt, dbg_rvalid;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_halted (cpu_halted),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .dbg_req    (dbg_req),
    .dbg_we     (dbg_we),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_gnt    (dbg_gnt),
    .dbg_rdata  (dbg_rdata),
    .dbg_rvalid (dbg_rvalid),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  always #5 clk = ~clk;

  // Environment RAM: combinational read, write on the rising edge.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  assign ram_rdata = ram[ram_addr];
  always @(posedge clk) if (ram_we) ram[ram_addr] <= ram_wdata;

  // Reference model state.
  logic [DW-1:0] mem_model [0:(1<<AW)-1];
  int            m_wait;
  logic          m_rvalid, m_stall, m_gnt;
  logic [DW-1:0] m_rdata;
  logic          obs_gnt;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_wait   = 0;
    m_rvalid = 1'b0;
    m_rdata  = '0;
    m_stall  = 1'b0;
    m_gnt    = 1'b0;
  endtask

  // One clock cycle: inputs already applied; checks combinational outputs
  // mid-cycle, then registered outputs just after the edge.
  task automatic step(input string tag);
    owner_e        own;
    logic          eff, frc, ewe, egnt, estall;
    logic [AW-1:0] ea;
    logic [DW-1:0] ew;
    #1;
    eff = cpu_req && !cpu_halted;
    frc = AGING && (m_wait == MW) && dbg_req;
    if (frc)          own = OWN_DBG;
    else if (eff)     own = OWN_CPU;
    else if (dbg_req) own = OWN_DBG;
    else              own = OWN_NONE;
    ewe = 1'b0; ea = '0; ew = '0;
    if (own == OWN_CPU) begin ewe = cpu_we; ea = cpu_addr; ew = cpu_wdata; end
    if (own == OWN_DBG) begin ewe = dbg_we; ea = dbg_addr; ew = dbg_wdata; end
    egnt   = (own == OWN_DBG);
    estall = egnt && eff;
    chk({tag, ".ram_we"},    32'(ram_we),    32'(ewe));
    chk({tag, ".ram_addr"},  32'(ram_addr),  32'(ea));
    chk({tag, ".ram_wdata"}, 32'(ram_wdata), 32'(ew));
    chk({tag, ".cpu_stall"}, 32'(cpu_stall), 32'(estall));
    chk({tag, ".dbg_gnt"},   32'(dbg_gnt),   32'(egnt));
    chk({tag, ".cpu_rdata"}, 32'(cpu_rdata), 32'(mem_model[ea]));
    obs_gnt = dbg_gnt;
    @(posedge clk);
    m_rvalid = egnt && !dbg_we;
    if (m_rvalid) m_rdata = mem_model[dbg_addr];
    if (ewe) mem_model[ea] = ew;
    if (dbg_req && !egnt) m_wait = (m_wait < 15) ? m_wait + 1 : 15;
    else                  m_wait = 0;
    m_stall = estall;
    m_gnt   = egnt;
    #1;
    chk({tag, ".dbg_rvalid"}, 32'(dbg_rvalid), 32'(m_rvalid));
    chk({tag, ".dbg_rdata"},  32'(dbg_rdata),  32'(m_rdata));
  endtask

  task automatic idle_inputs();
    cpu_halted = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".cpu_stall"},  32'(cpu_stall),  32'd0);
    chk({tag, ".dbg_gnt"},    32'(dbg_gnt),    32'd0);
    chk({tag, ".ram_we"},     32'(ram_we),     32'd0);
    chk({tag, ".dbg_rvalid"}, 32'(dbg_rvalid), 32'd0);
    chk({tag, ".dbg_rdata"},  32'(dbg_rdata),  32'd0);
  endtask

  initial begin
    int first_gnt;
    int stall_cnt;
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i]       = '0;
      mem_model[i] = '0;
    end
    model_reset();

    // Reset with every request active: nothing may leak through.
    rst = 1'b1;
    idle_inputs();
    cpu_req = 1'b1; cpu_we = 1'b1; dbg_req = 1'b1; dbg_we = 1'b1;
    #1;
    check_reset_outputs("rst_init");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle_inputs();

    // Load 0x155 at 0x005 and read it back through the debug port.
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 10'h005; dbg_wdata = 10'h155;
    step("dbg_wr5");
    dbg_we = 1'b0;
    step("dbg_rd5");
    chk("dbg_rd5.rdata_value", 32'(dbg_rdata), 32'h155);

    // Reset lands in the middle of another debug read of 0x005.
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    @(posedge clk);
    #1;
    dbg_req = 1'b0;
    rst = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("rst_rel");
    @(posedge clk);
    #1;
    check_reset_outputs("rst_post");

    // CPU store 0x2AB at 0x010, then CPU load of the same word.
    idle_inputs();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h010; cpu_wdata = 10'h2AB;
    step("cpu_wr");
    cpu_we = 1'b0;
    step("cpu_rd");
    cpu_addr = 10'h010;
    #1;
    chk("cpu_rd.value", 32'(cpu_rdata), 32'h2AB);
    #1;

    // Debug read of 0x010 with the CPU idle.
    idle_inputs();
    dbg_req = 1'b1; dbg_addr = 10'h010;
    step("dbg_rd10");
    chk("dbg_rd10.value", 32'(dbg_rdata), 32'h2AB);
    dbg_req = 1'b0;
    step("dbg_rd10_after");
    chk("dbg_rd10_after.rvalid", 32'(dbg_rvalid), 32'd0);

    // Halted CPU yields to a debug write of 0x3FF at 0x001.
    cpu_halted = 1'b1; cpu_req = 1'b1; cpu_addr = 10'h020;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 10'h001; dbg_wdata = 10'h3FF;
    step("halt_dbg_wr");
    idle_inputs();
    cpu_req = 1'b1; cpu_addr = 10'h001;
    step("halt_readback");
    chk("halt_readback.mem", 32'(ram[10'h001]), 32'h3FF);

    // Contention: both requests held for 20 cycles.
    idle_inputs();
    step("gap");
    cpu_req = 1'b1; cpu_addr = 10'h030;
    dbg_req = 1'b1; dbg_addr = 10'h010;
    first_gnt = 0;
    stall_cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      step($sformatf("contend%0d", i));
      if (obs_gnt && first_gnt == 0) first_gnt = i;
      if (m_stall) stall_cnt++;
    end
    chk("contend.first_gnt", 32'(first_gnt), AGING ? 32'd5 : 32'd0);
    chk("contend.stall_cycles", 32'(stall_cnt), AGING ? 32'd4 : 32'd0);

    // Random traffic obeying the hold-until-served handshake rules.
    idle_inputs();
    step("rand_gap");
    for (int i = 0; i < 300; i++) begin
      if (!m_stall) begin
        cpu_halted = ($urandom_range(0, 7) == 0);
        cpu_req    = $urandom_range(0, 1) == 1;
        cpu_we     = $urandom_range(0, 1) == 1;
        cpu_addr   = AW'($urandom_range(0, 15));
        cpu_wdata  = DW'($urandom);
      end
      if (dbg_req && !m_gnt) begin
        if ($urandom_range(0, 7) == 0) dbg_req = 1'b0;
      end else begin
        dbg_req   = $urandom_range(0, 1) == 1;
        dbg_we    = $urandom_range(0, 1) == 1;
        dbg_addr  = AW'($urandom_range(0, 15));
        dbg_wdata = DW'($urandom);
      end
      step($sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
